// File: rtl/sev_segm_reader.sv
// Snoops a multiplexed active-low 7-segment bus and recovers each digit's hex value (SEGM_DP_EN adds dp).
// A digit commits STABLE_CNT+2 cycles after its pins settle; pure observer, no backpressure.
module sev_segm_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef SEGM_DP_EN
  input  logic [7:0]          segm,
`else
  input  logic [6:0]          segm,
`endif
  input  logic [DIGITS-1:0]   dig_en,
  output logic [4*DIGITS-1:0] hex_out,
  output logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   err,
  output logic                upd,
`ifdef SEGM_DP_EN
  output logic [2:0]          upd_idx,
  output logic [DIGITS-1:0]   dp_out
`else
  output logic [2:0]          upd_idx
`endif
);

`ifdef SEGM_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif
  localparam logic [7:0] CNT_MAX    = 8'(STABLE_CNT);
  localparam logic [7:0] CNT_COMMIT = 8'(STABLE_CNT - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  logic [SW-1:0]     seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0] en_s1, en_s2;
  logic [2:0]        act_idx, idx_prev;
  logic [3:0]        zeros;
  logic              smp_vld, vld_prev, same;
  logic [7:0]        cnt, cnt_nxt;
  state_t            state, state_nxt;
  logic              commit;
  logic [3:0]        dec_hex, old_hex, new_hex;
  logic              dec_hit, dec_blank, dec_err;
  logic              old_blank, old_err, chg;
`ifdef SEGM_DP_EN
  logic              old_dp, new_dp;
`endif

  // Enables sync to all-ones so the idle bus reads as "no digit selected".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      en_s1  <= '1;
      en_s2  <= '1;
    end else begin
      seg_s1 <= segm;
      seg_s2 <= seg_s1;
      en_s1  <= dig_en;
      en_s2  <= en_s1;
    end
  end

  always_comb begin
    zeros   = '0;
    act_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!en_s2[i]) begin
        zeros   = zeros + 4'd1;
        act_idx = i[2:0];
      end
    end
    smp_vld = (zeros == 4'd1);
  end

  always_comb begin
    same = smp_vld && vld_prev && (seg_s2 == seg_prev) && (act_idx == idx_prev);
    if (!same)               cnt_nxt = '0;
    else if (cnt == CNT_MAX) cnt_nxt = cnt;
    else                     cnt_nxt = cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_prev <= '0;
      idx_prev <= '0;
      vld_prev <= 1'b0;
      cnt      <= '0;
      state    <= IDLE;
    end else begin
      seg_prev <= seg_s2;
      idx_prev <= act_idx;
      vld_prev <= smp_vld;
      cnt      <= cnt_nxt;
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE:  if (smp_vld) state_nxt = TRACK;
      TRACK: begin
        if (!smp_vld) state_nxt = IDLE;
        else if (same && cnt == CNT_COMMIT) begin
          commit    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!smp_vld)  state_nxt = IDLE;
        else if (!same) state_nxt = TRACK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Blank and error are mutually exclusive; a table hit clears both.
  always_comb begin
    dec_hit   = 1'b1;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    dec_hex   = 4'h0;
    case (seg_s2[6:0])
      7'h40: dec_hex = 4'h0;
      7'h79: dec_hex = 4'h1;
      7'h24: dec_hex = 4'h2;
      7'h30: dec_hex = 4'h3;
      7'h19: dec_hex = 4'h4;
      7'h12: dec_hex = 4'h5;
      7'h02: dec_hex = 4'h6;
      7'h78: dec_hex = 4'h7;
      7'h00: dec_hex = 4'h8;
      7'h10: dec_hex = 4'h9;
      7'h08: dec_hex = 4'hA;
      7'h03: dec_hex = 4'hB;
      7'h46: dec_hex = 4'hC;
      7'h21: dec_hex = 4'hD;
      7'h06: dec_hex = 4'hE;
      7'h0E: dec_hex = 4'hF;
      7'h7F: begin
        dec_hit   = 1'b0;
        dec_blank = 1'b1;
      end
      default: begin
        dec_hit = 1'b0;
        dec_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    old_hex   = '0;
    old_blank = 1'b0;
    old_err   = 1'b0;
`ifdef SEGM_DP_EN
    old_dp    = 1'b0;
`endif
    for (int i = 0; i < DIGITS; i++) begin
      if (act_idx == i[2:0]) begin
        old_hex   = hex_out[4*i +: 4];
        old_blank = blank[i];
        old_err   = err[i];
`ifdef SEGM_DP_EN
        old_dp    = dp_out[i];
`endif
      end
    end
    new_hex = dec_hit ? dec_hex : old_hex;
`ifdef SEGM_DP_EN
    new_dp = ~seg_s2[7];
    chg    = {new_hex, dec_blank, dec_err, new_dp} != {old_hex, old_blank, old_err, old_dp};
`else
    chg    = {new_hex, dec_blank, dec_err} != {old_hex, old_blank, old_err};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_out <= '0;
      blank   <= '1;
      err     <= '0;
      upd     <= 1'b0;
      upd_idx <= '0;
`ifdef SEGM_DP_EN
      dp_out  <= '0;
`endif
    end else begin
      upd <= commit && chg;
      if (commit && chg) upd_idx <= act_idx;
      for (int i = 0; i < DIGITS; i++) begin
        if (commit && act_idx == i[2:0]) begin
          hex_out[4*i +: 4] <= new_hex;
          blank[i]          <= dec_blank;
          err[i]            <= dec_err;
`ifdef SEGM_DP_EN
          dp_out[i]         <= new_dp;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_segm_reader.sv
// Randomised bench for sev_segm_reader: a run-length/latency reference model plus directed scenarios.
module tb_sev_segm_reader;
  localparam int ND = 4;
  localparam int SC = 8;
`ifdef SEGM_DP_EN
  localparam int SW = 8;
  localparam int VW = 7*ND + 4;
`else
  localparam int SW = 7;
  localparam int VW = 6*ND + 4;
`endif
  localparam logic [VW-1:0] RST_VEC = {{(4*ND){1'b0}}, {ND{1'b1}}, {(VW-5*ND){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] pat = 7'h7F;
  logic [ND-1:0] dig_en = '1;
  logic [SW-1:0] segm;
  logic [4*ND-1:0] hex_out;
  logic [ND-1:0] blank, err;
  logic upd;
  logic [2:0] upd_idx;
  logic [VW-1:0] dut_vec, exp_vec;
  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: committed outputs, current run of identical pin samples, 2-deep commit pipe.
  logic [4*ND-1:0] m_hex;
  logic [ND-1:0]   m_blank, m_err, m_dp;
  logic            m_upd;
  logic [2:0]      m_idx;
  int              run, run_idx;
  logic [SW-1:0]   run_seg;
  logic [1:0]      cq_v;
  logic [SW-1:0]   cq_seg [2];
  int              cq_idx [2];

`ifdef SEGM_DP_EN
  logic dp_n = 1'b1;
  logic [ND-1:0] dp_out;
  assign segm    = {dp_n, pat};
  assign dut_vec = {hex_out, blank, err, dp_out, upd, upd_idx};
  assign exp_vec = {m_hex, m_blank, m_err, m_dp, m_upd, m_idx};
`else
  assign segm    = pat;
  assign dut_vec = {hex_out, blank, err, upd, upd_idx};
  assign exp_vec = {m_hex, m_blank, m_err, m_upd, m_idx};
`endif

  always #5 clk = ~clk;

  sev_segm_reader #(.DIGITS(ND), .STABLE_CNT(SC)) dut (
    .clk(clk), .rst_n(rst_n), .segm(segm), .dig_en(dig_en),
    .hex_out(hex_out), .blank(blank), .err(err), .upd(upd),
`ifdef SEGM_DP_EN
    .upd_idx(upd_idx), .dp_out(dp_out)
`else
    .upd_idx(upd_idx)
`endif
  );

  // A pattern on the pins for SC+1 consecutive edges is committed and visible two edges later.
  always @(posedge clk or negedge rst_n) begin : model
    int zc, ix, ci;
    logic hit, nb, ne, nd;
    logic [3:0] h;
    if (!rst_n) begin
      m_hex = '0; m_blank = '1; m_err = '0; m_dp = '0; m_upd = 1'b0; m_idx = '0;
      run = 0; run_idx = 0; run_seg = '0; cq_v = '0;
      cq_seg[0] = '0; cq_seg[1] = '0; cq_idx[0] = 0; cq_idx[1] = 0;
    end else begin
      m_upd = 1'b0;
      if (cq_v[1]) begin
        ci  = cq_idx[1];
        hit = 1'b0;
        h   = m_hex[4*ci +: 4];
        for (int v = 0; v < 16; v++)
          if (cq_seg[1][6:0] == tbl[v]) begin hit = 1'b1; h = 4'(v); end
        nb = (cq_seg[1][6:0] == 7'h7F);
        ne = !hit && !nb;
`ifdef SEGM_DP_EN
        nd = ~cq_seg[1][SW-1];
`else
        nd = 1'b0;
`endif
        if ({h, nb, ne, nd} != {m_hex[4*ci +: 4], m_blank[ci], m_err[ci], m_dp[ci]}) begin
          m_upd = 1'b1;
          m_idx = 3'(ci);
        end
        m_hex[4*ci +: 4] = h; m_blank[ci] = nb; m_err[ci] = ne; m_dp[ci] = nd;
      end
      cq_v[1] = cq_v[0]; cq_seg[1] = cq_seg[0]; cq_idx[1] = cq_idx[0];
      zc = 0; ix = 0;
      for (int i = 0; i < ND; i++) if (!dig_en[i]) begin zc++; ix = i; end
      if (zc != 1) run = 0;
      else if (run > 0 && segm == run_seg && ix == run_idx) run++;
      else begin run = 1; run_seg = segm; run_idx = ix; end
      cq_v[0] = (run == SC + 1); cq_seg[0] = segm; cq_idx[0] = run_idx;
    end
  end

  task automatic pulse_reset();
    dig_en = '1; pat = 7'h7F;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, RST_VEC); end
    rst_n = 1'b1; dig_en = 4'b1011; pat = tbl[5];
    for (int k = 0; k < SC + 5; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL reset_pre k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
    pat = tbl[3];
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL reset_async got=%h exp=%h", dut_vec, RST_VEC); end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < SC + 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k <= SC + 1) begin
        n_cmp++;
        if (upd !== 1'b0) begin n_bad++; $display("FAIL reset_no_upd k=%0d got=%b exp=0", k, upd); end
      end
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL reset_post k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
    end
  endtask

  task automatic test_commit();
    pulse_reset();
    dig_en = 4'b1110; pat = 7'b0100100;
    for (int k = 0; k < SC + 6; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL commit_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (k == SC + 1 || k == SC + 3) begin
        n_cmp++;
        if (upd !== 1'b0) begin n_bad++; $display("FAIL commit_no_pulse k=%0d got=%b exp=0", k, upd); end
      end
      if (k == SC + 2) begin
        n_cmp++;
        if ({hex_out[3:0], upd, upd_idx} !== {4'h2, 1'b1, 3'd0}) begin
          n_bad++; $display("FAIL commit_latency got=%h/%b/%0d exp=2/1/0", hex_out[3:0], upd, upd_idx);
        end
      end
    end
  endtask

  task automatic test_glitch();
    pulse_reset();
    dig_en = 4'b1110; pat = 7'b0100100;
    for (int k = 0; k < SC + 10; k++) begin
      @(posedge clk); @(negedge clk);
      pat = (k == 3) ? 7'h00 : 7'b0100100;
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL glitch_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (k == SC + 2) begin
        n_cmp++;
        if ({hex_out[3:0], upd} !== {4'h0, 1'b0}) begin n_bad++; $display("FAIL glitch_early got=%h/%b exp=0/0", hex_out[3:0], upd); end
      end
      if (k == SC + 7) begin
        n_cmp++;
        if ({hex_out[3:0], upd} !== {4'h2, 1'b1}) begin n_bad++; $display("FAIL glitch_late got=%h/%b exp=2/1", hex_out[3:0], upd); end
      end
    end
  endtask

  task automatic test_scan();
    logic [6:0] shown [4];
    logic [ND-1:0] one = 1;
    int pulses;
    shown[0] = tbl[1]; shown[1] = tbl[10]; shown[2] = 7'h7F; shown[3] = 7'h3F;
    for (int rot = 0; rot < 3; rot++) begin
      pulses = 0;
      for (int d = 0; d < 4; d++) begin
        dig_en = ~(one << d);
        pat = (rot == 0) ? tbl[5] : shown[d];
        for (int c = 0; c < 20; c++) begin
          @(posedge clk); @(negedge clk);
          if (upd === 1'b1) pulses++;
          n_cmp++;
          if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL scan_model rot=%0d d=%0d c=%0d got=%h exp=%h", rot, d, c, dut_vec, exp_vec); end
        end
      end
      if (rot == 1) begin
        n_cmp++;
        if (pulses != 4) begin n_bad++; $display("FAIL scan_pulses1 got=%0d exp=4", pulses); end
        n_cmp++;
        if ({hex_out[7:0], blank[2], err[3]} !== {8'hA1, 1'b1, 1'b1}) begin
          n_bad++; $display("FAIL scan_values got=%h/%b/%b exp=a1/1/1", hex_out[7:0], blank[2], err[3]);
        end
      end
      if (rot == 2) begin
        n_cmp++;
        if (pulses != 0) begin n_bad++; $display("FAIL scan_pulses2 got=%0d exp=0", pulses); end
      end
    end
  endtask

  task automatic test_invalid();
    logic [VW-1:0] snap;
    snap = exp_vec;
    pat = tbl[9];
    for (int k = 0; k < 100; k++) begin
      dig_en = (k < 50) ? 4'b1100 : 4'b1111;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (dut_vec !== snap) begin n_bad++; $display("FAIL invalid_hold k=%0d got=%h exp=%h", k, dut_vec, snap); end
    end
  endtask

  task automatic test_random();
    logic [6:0] base;
    logic [ND-1:0] one = 1;
    int hold, gpos;
    logic gl;
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 9))
        7:       base = 7'h7F;
        8, 9:    base = 7'($urandom);
        default: base = tbl[$urandom_range(0, 15)];
      endcase
      if ($urandom_range(0, 9) < 8) dig_en = ~(one << $urandom_range(0, ND - 1));
      else                          dig_en = ND'($urandom);
`ifdef SEGM_DP_EN
      dp_n = 1'($urandom);
`endif
      hold = $urandom_range(1, 16);
      gl   = ($urandom_range(0, 6) == 0);
      gpos = $urandom_range(0, hold - 1);
      for (int c = 0; c < hold; c++) begin
        pat = (gl && c == gpos) ? base ^ 7'($urandom_range(1, 127)) : base;
        @(posedge clk); @(negedge clk);
        n_cmp++;
        if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL random s=%0d c=%0d got=%h exp=%h", s, c, dut_vec, exp_vec); end
      end
    end
  endtask

`ifdef SEGM_DP_EN
  task automatic test_dp();
    pulse_reset();
    dig_en = 4'b1101; pat = tbl[8]; dp_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) dp_n = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin n_bad++; $display("FAIL dp_model k=%0d got=%h exp=%h", k, dut_vec, exp_vec); end
      if (k == 20 + SC + 2) begin
        n_cmp++;
        if ({dp_out[1], upd, upd_idx, hex_out[7:4]} !== {1'b1, 1'b1, 3'd1, 4'h8}) begin
          n_bad++; $display("FAIL dp_toggle got=%b/%b/%0d/%h exp=1/1/1/8", dp_out[1], upd, upd_idx, hex_out[7:4]);
        end
      end
    end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_commit();
    test_glitch();
    test_scan();
    test_invalid();
    test_random();
`ifdef SEGM_DP_EN
    test_dp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
